// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch / IF-ID stage.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      KILL  = 2'd3
   } if_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] WORD_INC  = 32'd4;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      logic [31:0] result;
      if (value == 32'hFFFF_FFFF) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_id_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/if_skid_buf.sv
// Single-entry skid buffer holding {instruction, pc+4} while decode is stalled.
module if_skid_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  logic [63:0] din,
   output logic [63:0] dout,
   output logic        valid
);

   logic [63:0] data_r;
   logic        valid_r;

   // Entry storage; clear wins over load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= 64'd0;
         valid_r <= 1'b0;
      end else if (clear) begin
         data_r  <= 64'd0;
         valid_r <= 1'b0;
      end else if (load) begin
         data_r  <= din;
         valid_r <= 1'b1;
      end else begin
         data_r  <= data_r;
         valid_r <= valid_r;
      end
   end

   assign dout  = data_r;
   assign valid = valid_r;

endmodule

// File: rtl/if_id_stage.sv
// Fetch FSM with one outstanding imem request, skid buffer and IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_id_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall_D,
   input  logic          redirect_X,
   input  logic [31:0]   target_X,
   if_id_stage_if.master imem,
   output logic [31:0]   Ins_D,
   output logic [31:0]   PC_plus4_D,
   output logic          valid_D
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   kill_cnt
`endif
);

   if_state_t   state_r;
   if_state_t   state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_s;
   logic [31:0] pc_plus4_s;
   logic        fresh_r;
   logic        req_s;
   logic        discard_s;
   logic        load_s;
   logic [31:0] load_ins_s;
   logic [31:0] load_pc4_s;
   logic        skid_load_s;
   logic        skid_clear_s;
   logic [63:0] skid_data_s;
   logic        skid_valid_s;
   logic [31:0] ins_r;
   logic [31:0] pc4_r;
   logic        valid_r;

   assign pc_plus4_s = pc_r + WORD_INC;

   if_skid_buf u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load_s),
      .clear (skid_clear_s),
      .din   ({imem.imem_rdata, pc_plus4_s}),
      .dout  (skid_data_s),
      .valid (skid_valid_s)
   );

   // Next-state, pc and IF/ID load decode.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      req_s        = 1'b0;
      discard_s    = 1'b0;
      load_s       = 1'b0;
      load_ins_s   = imem.imem_rdata;
      load_pc4_s   = pc_plus4_s;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
      case (state_r)
         FETCH: begin
            // A response in the first cycle after reset belongs to a pre-reset request.
            if (fresh_r && imem.imem_rvalid) begin
               discard_s = 1'b1;
               state_s   = FETCH;
               if (redirect_X) begin
                  pc_s = target_X;
               end else begin
                  pc_s = pc_r;
               end
            end else begin
               req_s = 1'b1;
               if (redirect_X) begin
                  pc_s    = target_X;
                  state_s = KILL;
               end else begin
                  state_s = WAIT;
               end
            end
         end
         WAIT: begin
            if (redirect_X) begin
               pc_s = target_X;
               if (imem.imem_rvalid) begin
                  discard_s = 1'b1;
                  state_s   = FETCH;
               end else begin
                  state_s = KILL;
               end
            end else if (imem.imem_rvalid) begin
               if (stall_D) begin
                  skid_load_s = 1'b1;
                  state_s     = HOLD;
               end else begin
                  load_s  = 1'b1;
                  pc_s    = pc_plus4_s;
                  state_s = FETCH;
               end
            end else begin
               state_s = WAIT;
            end
         end
         HOLD: begin
            if (redirect_X) begin
               skid_clear_s = 1'b1;
               pc_s         = target_X;
               state_s      = FETCH;
            end else if (!stall_D) begin
               load_s       = skid_valid_s;
               load_ins_s   = skid_data_s[63:32];
               load_pc4_s   = skid_data_s[31:0];
               skid_clear_s = 1'b1;
               pc_s         = pc_plus4_s;
               state_s      = FETCH;
            end else begin
               state_s = HOLD;
            end
         end
         KILL: begin
            // With the stale response consumed there is nothing left to wait for.
            if (imem.imem_rvalid) begin
               discard_s = 1'b1;
               state_s   = FETCH;
            end else begin
               state_s = KILL;
            end
            if (redirect_X) begin
               pc_s = target_X;
            end else begin
               pc_s = pc_r;
            end
         end
         default: begin
            state_s = FETCH;
         end
      endcase
   end

   // FSM state, fetch pc and post-reset flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FETCH;
         pc_r    <= RESET_PC;
         fresh_r <= 1'b1;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         fresh_r <= 1'b0;
      end
   end

   // IF/ID register: redirect flush > stall hold > load > bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_r   <= NOP_INSTR;
         pc4_r   <= 32'd0;
         valid_r <= 1'b0;
      end else if (redirect_X) begin
         ins_r   <= NOP_INSTR;
         pc4_r   <= pc4_r;
         valid_r <= 1'b0;
      end else if (stall_D) begin
         ins_r   <= ins_r;
         pc4_r   <= pc4_r;
         valid_r <= valid_r;
      end else if (load_s) begin
         ins_r   <= load_ins_s;
         pc4_r   <= load_pc4_s;
         valid_r <= 1'b1;
      end else begin
         ins_r   <= NOP_INSTR;
         pc4_r   <= pc4_r;
         valid_r <= 1'b0;
      end
   end

   assign imem.imem_req  = rst_n & req_s;
   assign imem.imem_addr = pc_r;
   assign Ins_D          = ins_r;
   assign PC_plus4_D     = pc4_r;
   assign valid_D        = valid_r;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] kill_cnt_r;

   // Saturating HOLD-cycle and discarded-response counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
         kill_cnt_r  <= 32'd0;
      end else begin
         if (state_r == HOLD) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (discard_s) begin
            kill_cnt_r <= sat_inc32(kill_cnt_r);
         end else begin
            kill_cnt_r <= kill_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign kill_cnt  = kill_cnt_r;
`else
   logic unused_discard_s;
   assign unused_discard_s = discard_s;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: cycle-by-cycle stimulus with hand-computed expectations.
module tb_if_id_stage;
   logic        clk;
   logic        rst_n;
   logic        stall_D;
   logic        redirect_X;
   logic [31:0] target_X;
   logic [31:0] Ins_D;
   logic [31:0] PC_plus4_D;
   logic        valid_D;
   int          checks;
   int          failures;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] kill_cnt;
`endif

   if_id_stage_if imem_bus ();

   if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_D    (stall_D),
      .redirect_X (redirect_X),
      .target_X   (target_X),
      .imem       (imem_bus),
      .Ins_D      (Ins_D),
      .PC_plus4_D (PC_plus4_D),
      .valid_D    (valid_D)
`ifdef IF_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .kill_cnt   (kill_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] ins, input logic [31:0] pc4, input logic vld);
      chk({tag, ".req"},   {31'd0, imem_bus.imem_req}, {31'd0, req});
      chk({tag, ".addr"},  imem_bus.imem_addr, addr);
      chk({tag, ".ins"},   Ins_D, ins);
      chk({tag, ".pc4"},   PC_plus4_D, pc4);
      chk({tag, ".valid"}, {31'd0, valid_D}, {31'd0, vld});
   endtask

   // Advance one clock and land 2 time units past the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic stall, input logic redir, input logic [31:0] tgt,
                        input logic rv, input logic [31:0] rd);
      stall_D              = stall;
      redirect_X           = redir;
      target_X             = tgt;
      imem_bus.imem_rvalid = rv;
      imem_bus.imem_rdata  = rd;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      tick();
      chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

      // Cycle 1: first fetch at RESET_PC.
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c1_fetch", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h2008_0005);
      chk_out("c2_wait", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c3_load", 1'b1, 32'h4, 32'h2008_0005, 32'h4, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0001);
      chk_out("c4_bubble", 1'b0, 32'h4, 32'h0, 32'h4, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c5_load", 1'b1, 32'h8, 32'hAAAA_0001, 32'h8, 1'b1);
      tick();

      // Response for pc=8 arrives under a 3-cycle stall.
      drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hBBBB_0002);
      chk_out("c6_wait", 1'b0, 32'h8, 32'h0, 32'h8, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c7_hold", 1'b0, 32'h8, 32'h0, 32'h8, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c8_hold", 1'b0, 32'h8, 32'h0, 32'h8, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c9_hold", 1'b0, 32'h8, 32'h0, 32'h8, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c10_skid", 1'b1, 32'hC, 32'hBBBB_0002, 32'hC, 1'b1);
      tick();

      // Redirect in WAIT; the stale response shows up 3 cycles after the request.
      drive(1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
      chk_out("c11_wait", 1'b0, 32'hC, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c12_kill", 1'b0, 32'h40, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
      chk_out("c13_kill", 1'b0, 32'h40, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c14_fetch", 1'b1, 32'h40, 32'h0, 32'hC, 1'b0);
      tick();

      // Redirect and rvalid together in WAIT: word dropped, fetch at target next.
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hCCCC_0003);
      chk_out("c15_wait", 1'b0, 32'h40, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c16_fetch", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h1234_5678);
      chk_out("c17_wait", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hC, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c18_wrap", 1'b1, 32'h0, 32'h1234_5678, 32'h0, 1'b1);
      tick();

      // Reset in the middle of WAIT, late response right after release.
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("c19_wait", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_out("mid_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hEEEE_0004);
      chk_out("rel_stale", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("rel_fetch", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h5555_0006);
      chk_out("rel_wait", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_out("rel_load", 1'b1, 32'h4, 32'h5555_0006, 32'h4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
